// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer-width default and Gray/binary conversion.
package fifo_pkg;

   localparam int unsigned PTR_WIDTH_DEF = 3;

   // Widest pointer the helpers handle; callers zero-extend into this word.
   localparam int unsigned PTR_MAX = 32;

   typedef logic [PTR_MAX-1:0] ptr_word_t;

   // Width-agnostic: a zero-extended binary value yields its zero-extended Gray code.
   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Width-agnostic: the zero MSBs above the real width leave the XOR cascade untouched.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b = g;
      for (int i = PTR_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rptr_handler_ctrl.sv
// Read-domain pointer handler for the async FIFO: binary/Gray read pointers,
// registered empty/almost-empty/occupancy, read-valid and sticky underflow.
module rptr_handler_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned PTR_WIDTH     = PTR_WIDTH_DEF,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 r_en,
   input  logic                 clr_underflow,
   input  logic [PTR_WIDTH:0]   g_wptr_sync,
   output logic [PTR_WIDTH:0]   b_rptr,
   output logic [PTR_WIDTH:0]   g_rptr,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [PTR_WIDTH:0]   rd_level,
   output logic                 rd_valid,
   output logic                 underflow
);

   localparam int unsigned PW = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] AE_THRESH = PW'(AEMPTY_THRESH);

   logic                 rd_accept;
   logic [PTR_WIDTH:0]   b_rptr_next;
   logic [PTR_WIDTH:0]   g_rptr_next;
   logic [PTR_WIDTH:0]   b_wptr_sync;
   logic [PTR_WIDTH:0]   level_next;

   // Next-state pointers and occupancy, all taken against the post-read pointer so the
   // status flags land on the same edge as the pointer update.
   always_comb begin
      rd_accept   = r_en & ~empty;
      b_rptr_next = b_rptr + PW'(rd_accept);
      g_rptr_next = PW'(bin2gray(ptr_word_t'(b_rptr_next)));
      b_wptr_sync = PW'(gray2bin(ptr_word_t'(g_wptr_sync)));
      level_next  = b_wptr_sync - b_rptr_next;
   end

   // Pointer, status and underflow registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         b_rptr       <= '0;
         g_rptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
         rd_valid     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         b_rptr       <= b_rptr_next;
         g_rptr       <= g_rptr_next;
         // Full-width Gray compare: equal Gray codes mean equal pointers including wrap bit.
         empty        <= (g_rptr_next == g_wptr_sync);
         almost_empty <= (level_next <= AE_THRESH);
         rd_level     <= level_next;
         rd_valid     <= rd_accept;
         // Set has priority over clear so a same-cycle underflow is never lost.
         if (r_en && empty) begin
            underflow <= 1'b1;
         end else if (clr_underflow) begin
            underflow <= 1'b0;
         end
      end
   end

   // The Gray pointer crosses into the write domain, so it may flip at most one bit per edge.
   a_gray_one_bit: assert property (@(posedge rclk) disable iff (!rrst_n)
      $countones(g_rptr ^ $past(g_rptr)) <= 1);

endmodule

// File: tb/tb_rptr_handler_ctrl.sv
// Bench for rptr_handler_ctrl: directed vector table, async-reset sequences and
// randomized traffic against an integer-arithmetic occupancy model.
module tb_rptr_handler_ctrl;

   localparam int unsigned PW  = 3;
   localparam int unsigned MOD = 16;

   logic       rclk;
   logic       rrst_n;
   logic       r_en;
   logic       clr_underflow;
   logic [3:0] g_wptr_sync;
   logic [3:0] b_rptr;
   logic [3:0] g_rptr;
   logic       empty;
   logic       almost_empty;
   logic [3:0] rd_level;
   logic       rd_valid;
   logic       underflow;

   int checks;
   int failures;

   rptr_handler_ctrl #(
      .PTR_WIDTH     (PW),
      .AEMPTY_THRESH (2)
   ) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .r_en          (r_en),
      .clr_underflow (clr_underflow),
      .g_wptr_sync   (g_wptr_sync),
      .b_rptr        (b_rptr),
      .g_rptr        (g_rptr),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .rd_level      (rd_level),
      .rd_valid      (rd_valid),
      .underflow     (underflow)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   typedef struct {
      logic r_en;
      logic clr;
      int   w;
      int   b;
      logic e;
      int   lvl;
      logic ae;
      logic v;
      logic uf;
   } vec_t;

   vec_t vecs[$];

   function automatic int gray(input int x);
      return (x ^ (x >> 1)) & (MOD - 1);
   endfunction

   task automatic drive(input logic re, input logic clr, input int w);
      r_en          = re;
      clr_underflow = clr;
      g_wptr_sync   = 4'(gray(w % MOD));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input int b, input logic e, input int lvl,
                            input logic ae, input logic v, input logic uf);
      chk({tag, ".b_rptr"},       32'(b_rptr),       32'(b));
      chk({tag, ".g_rptr"},       32'(g_rptr),       32'(gray(b)));
      chk({tag, ".empty"},        32'(empty),        32'(e));
      chk({tag, ".rd_level"},     32'(rd_level),     32'(lvl));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
      chk({tag, ".rd_valid"},     32'(rd_valid),     32'(v));
      chk({tag, ".underflow"},    32'(underflow),    32'(uf));
   endtask

   // Reference model state, expressed as plain modulo-16 counters.
   int   m_r, m_w, m_lvl;
   logic m_empty, m_ae, m_v, m_uf;

   initial begin
      checks   = 0;
      failures = 0;

      // r_en, clr, w | b, empty, level, aempty, valid, underflow
      vecs.push_back('{1'b1, 1'b0,  3,  1, 1'b0, 2, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  3,  2, 1'b0, 1, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  3,  3, 1'b1, 0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1,  3,  3, 1'b1, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 11,  3, 1'b0, 8, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  4, 1'b0, 7, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  5, 1'b0, 6, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  6, 1'b0, 5, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  7, 1'b0, 4, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  8, 1'b0, 3, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11,  9, 1'b0, 2, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11, 10, 1'b0, 1, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11, 11, 1'b1, 0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 11, 11, 1'b1, 0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 11, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0,  1, 11, 1'b0, 6, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1, 12, 1'b0, 5, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1, 13, 1'b0, 4, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1, 14, 1'b0, 3, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1, 15, 1'b0, 2, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1,  0, 1'b0, 1, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0,  1,  1, 1'b1, 0, 1'b1, 1'b1, 1'b0});

      // Reset held with a read requested and a non-empty write pointer.
      rrst_n = 1'b0;
      drive(1'b1, 1'b0, 3);
      repeat (3) @(posedge rclk);
      #1;
      check_all("reset", 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      rrst_n = 1'b1;
      drive(1'b0, 1'b0, 3);
      @(posedge rclk);
      #1;
      check_all("release", 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r_en, vecs[i].clr, vecs[i].w);
         @(posedge rclk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].lvl, vecs[i].ae,
                   vecs[i].v, vecs[i].uf);
      end

      // Mid-burst asynchronous reset.
      drive(1'b0, 1'b0, 7);
      @(posedge rclk);
      #1;
      check_all("pre_burst", 1, 1'b0, 6, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 7);
      @(posedge rclk);
      #1;
      check_all("burst", 2, 1'b0, 5, 1'b0, 1'b1, 1'b0);
      #1 rrst_n = 1'b0;
      #2;
      check_all("async_rst", 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      #3 rrst_n = 1'b1;
      drive(1'b0, 1'b0, 7);
      @(posedge rclk);
      #1;
      check_all("rst_recover", 0, 1'b0, 7, 1'b0, 1'b0, 1'b0);

      // Randomized traffic against the counter model.
      m_r = 0; m_w = 7; m_lvl = 7;
      m_empty = 1'b0; m_ae = 1'b0; m_v = 1'b0; m_uf = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic re, clr, acc;
         re  = (($urandom % 3) != 0);
         clr = (($urandom % 8) == 0);
         if ((($urandom % 2) == 1) && (((m_w - m_r + MOD) % MOD) < 8)) begin
            m_w = (m_w + 1) % MOD;
         end
         drive(re, clr, m_w);
         acc     = re && !m_empty;
         m_uf    = (re && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
         m_r     = (m_r + int'(acc)) % MOD;
         m_empty = (m_r == m_w);
         m_lvl   = (m_w - m_r + MOD) % MOD;
         m_ae    = (m_lvl <= 2);
         m_v     = acc;
         @(posedge rclk);
         #1;
         check_all($sformatf("rand%0d", n), m_r, m_empty, m_lvl, m_ae, m_v, m_uf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
